entradas_condicionador: RTL and testbench
=========================================

Name: entradas_condicionador

Overview:
- Upstream stage of the main controller state machine; drives that machine's start, PG, CH, RO, EB and CQ inputs.
- Synchronises and debounces five raw switch/sensor lines (start, PG, CH, RO, EB) into clean levels.
- Runs the process timer whose expiry is the controller's CQ input.
- All outputs are registered and glitch-free, so the JK flip-flops downstream see at most one transition per input per settling period.

Parameters:
- DEB_CYCLES, 16: consecutive stable synchronised samples required before a debounced output changes (legal range 2..255).
- TIMER_CYCLES, 1000: clock cycles from timer_run rising to CQ asserting (legal range 1..65535).
- CHATTER_LIMIT, 8: aborted debounce attempts before a chatter fault is flagged (optional feature only, legal range 1..255).

Ports:
- clock, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- raw_start, input, 1: raw start switch, asynchronous to clock.
- raw_pg, input, 1: raw PG sensor, asynchronous.
- raw_ch, input, 1: raw CH sensor, asynchronous.
- raw_ro, input, 1: raw RO sensor, asynchronous.
- raw_eb, input, 1: raw EB sensor, asynchronous.
- timer_run, input, 1: timer enable, decoded from controller state; synchronous to clock.
- start, output, 1: debounced start.
- PG, output, 1: debounced PG.
- CH, output, 1: debounced CH.
- RO, output, 1: debounced RO.
- EB, output, 1: debounced EB.
- CQ, output, 1: timer-expired level.
- sensor_fault, output, 1: chatter fault flag (optional feature only).

Behaviour:
- Reset:
  - Synchronous, active-high, sampled on the rising edge of clock.
  - All synchronisers, debounced outputs, debounce counters, timer, CQ and sensor_fault go to 0 at the first edge with reset=1.
  - Reset asserted mid-operation behaves exactly like power-up reset: it discards pending debounce counts and timer progress.
- Synchroniser: each raw line passes through two flip-flops. The value s is the second stage.
- Debounce, one independent channel per line:
  - Each channel holds an output register out and a counter cnt, 8 bits wide.
  - If s == out: cnt is cleared to 0.
  - If s != out: cnt increments.
  - When cnt reaches DEB_CYCLES-1 while s != out: out takes s on that same edge and cnt clears.
  - Latency from a raw edge to the output change is 2 synchroniser cycles plus DEB_CYCLES cycles, i.e. 18 cycles at default settings.
  - A glitch shorter than DEB_CYCLES synchronised samples never reaches the output.
  - The counter never wraps; it saturates only through the compare.
- Timer:
  - 16-bit counter tcnt. While timer_run=0: tcnt=0 and CQ=0.
  - While timer_run=1 and CQ=0: tcnt increments.
  - When tcnt reaches TIMER_CYCLES-1: CQ=1 on the next edge.
  - CQ then holds 1, and tcnt holds its value, until timer_run drops.
  - CQ first rises TIMER_CYCLES edges after the first edge that samples timer_run=1.
  - Dropping timer_run at any count, including the same cycle CQ would assert, clears tcnt and CQ on that edge. timer_run low takes priority.
  - Re-raising timer_run restarts the count from 0. There is no accumulation.
- Channels are fully independent. Simultaneous changes on several raw lines settle in parallel, with identical latency.
- No combinational path from any input to any output.

Optional Feature:
- Macro: ENTRADAS_CHATTER_EN.
- Defined: each channel has an 8-bit abort counter.
  - An abort is a cycle where cnt != 0, s == out and the counter clears without committing. Each abort increments the abort counter.
  - A committed output change clears the abort counter, as do 256 consecutive stable cycles.
  - When any channel's abort counter reaches CHATTER_LIMIT, sensor_fault becomes 1.
  - sensor_fault is sticky and is cleared only by reset.
  - Debounced outputs keep their normal debounce behaviour regardless of sensor_fault.
- Undefined: the abort counters are not built and sensor_fault is tied to 0.

Test Plan:
- Reset dominance: reset=1 for 3 cycles with all raw inputs=1 -> all outputs 0; release reset, hold inputs -> start/PG/CH/RO/EB rise exactly 18 cycles later (DEB_CYCLES=16).
- Glitch rejection: raw_ro pulse of 10 cycles -> RO stays 0; raw_ro held 20 cycles -> RO rises 18 cycles after the raw edge and stays 1.
- Parallel channels: raw_pg and raw_eb rise on the same edge, raw_ch falls 5 cycles later -> PG and EB rise on the same cycle; CH falls 5 cycles after that.
- Timer expiry: TIMER_CYCLES=10, timer_run held 1 -> CQ rises on the 10th edge and holds; drop timer_run -> CQ=0 on the next edge.
- Timer abort/restart: timer_run high 7 cycles, low 1 cycle, high again -> CQ rises 10 edges after the re-assertion, not 3.
- With ENTRADAS_CHATTER_EN, CHATTER_LIMIT=4: raw_ch toggles every 6 cycles for 60 cycles -> CH never changes; sensor_fault=1 after the 4th abort and stays 1 until reset. Same stimulus without the macro -> sensor_fault stays 0.

Source files
------------

// File: rtl/entradas_condicionador_if.sv
// Controller-facing bundle of entradas_condicionador: the timer enable coming back
// from the controller and the clean levels (start/PG/CH/RO/EB/CQ, sensor_fault) going to it.
interface entradas_condicionador_if;
  logic timer_run;
  logic start;
  logic PG;
  logic CH;
  logic RO;
  logic EB;
  logic CQ;
  logic sensor_fault;

  modport master (
    input  timer_run,
    output start, PG, CH, RO, EB, CQ, sensor_fault
  );

  modport slave (
    output timer_run,
    input  start, PG, CH, RO, EB, CQ, sensor_fault
  );
endinterface

// File: rtl/entradas_condicionador.sv
// Input conditioner for the main controller: 2-FF synchronisers, per-line debouncers and the CQ process timer.
// Optional chatter detection (sticky sensor_fault) is built only when ENTRADAS_CHATTER_EN is defined.
module entradas_condicionador #(
  parameter int DEB_CYCLES    = 16,
  parameter int TIMER_CYCLES  = 1000,
  parameter int CHATTER_LIMIT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_start,
  input  logic raw_pg,
  input  logic raw_ch,
  input  logic raw_ro,
  input  logic raw_eb,
  entradas_condicionador_if.master ctl
);

  localparam int NUM_CH = 5;
  localparam logic [7:0]  DEB_LAST   = 8'(DEB_CYCLES - 1);
  localparam logic [15:0] TIMER_LAST = 16'(TIMER_CYCLES - 1);

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] sync_a;
  logic [NUM_CH-1:0] sync_b;
  logic [NUM_CH-1:0] deb_out;
  logic [7:0]        deb_cnt [NUM_CH];
  logic [15:0]       tcnt;
  logic              cq;

  assign raw = {raw_eb, raw_ro, raw_ch, raw_pg, raw_start};

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // A channel commits only after DEB_CYCLES consecutive disagreeing samples; any agreeing sample restarts the count.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_deb
    always_ff @(posedge clock) begin
      if (reset) begin
        deb_out[i] <= 1'b0;
        deb_cnt[i] <= 8'd0;
      end else if (sync_b[i] == deb_out[i]) begin
        deb_cnt[i] <= 8'd0;
      end else if (deb_cnt[i] == DEB_LAST) begin
        deb_out[i] <= sync_b[i];
        deb_cnt[i] <= 8'd0;
      end else begin
        deb_cnt[i] <= deb_cnt[i] + 8'd1;
      end
    end
  end

  // timer_run low always wins, so dropping it on the expiry cycle still clears everything.
  always_ff @(posedge clock) begin
    if (reset || !ctl.timer_run) begin
      tcnt <= 16'd0;
      cq   <= 1'b0;
    end else if (!cq) begin
      if (tcnt == TIMER_LAST) begin
        cq <= 1'b1;
      end else begin
        tcnt <= tcnt + 16'd1;
      end
    end
  end

`ifdef ENTRADAS_CHATTER_EN
  localparam logic [7:0] CHATTER_MAX = 8'(CHATTER_LIMIT);

  logic [7:0]        abort_cnt  [NUM_CH];
  logic [7:0]        stable_cnt [NUM_CH];
  logic [NUM_CH-1:0] chatter_hit;
  logic              fault;

  // An abort is a partially counted debounce that falls back to the current level; 256 quiet cycles forgive them.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_chatter
    always_ff @(posedge clock) begin
      if (reset) begin
        abort_cnt[i]  <= 8'd0;
        stable_cnt[i] <= 8'd0;
      end else if (sync_b[i] != deb_out[i]) begin
        stable_cnt[i] <= 8'd0;
        if (deb_cnt[i] == DEB_LAST) begin
          abort_cnt[i] <= 8'd0;
        end
      end else if (deb_cnt[i] != 8'd0) begin
        stable_cnt[i] <= 8'd0;
        if (abort_cnt[i] != 8'hFF) begin
          abort_cnt[i] <= abort_cnt[i] + 8'd1;
        end
      end else begin
        stable_cnt[i] <= stable_cnt[i] + 8'd1;
        if (stable_cnt[i] == 8'hFF) begin
          abort_cnt[i] <= 8'd0;
        end
      end
    end

    assign chatter_hit[i] = (abort_cnt[i] >= CHATTER_MAX);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fault <= 1'b0;
    end else if (|chatter_hit) begin
      fault <= 1'b1;
    end
  end

  assign ctl.sensor_fault = fault;
`else
  // CHATTER_LIMIT only matters when the abort counters are built.
  logic unused_chatter_cfg;
  assign unused_chatter_cfg = (CHATTER_LIMIT > 0);
  assign ctl.sensor_fault   = 1'b0;
`endif

  assign ctl.start = deb_out[0];
  assign ctl.PG    = deb_out[1];
  assign ctl.CH    = deb_out[2];
  assign ctl.RO    = deb_out[3];
  assign ctl.EB    = deb_out[4];
  assign ctl.CQ    = cq;

endmodule

// File: tb/tb_entradas_condicionador.sv
// Self-checking bench for entradas_condicionador: directed plan steps followed by random traffic,
// checked every cycle against a window/elapsed-time reference model.
module tb_entradas_condicionador;

  localparam int DEB  = 16;
  localparam int TMR  = 10;
  localparam int CHAT = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic raw_start = 1'b0;
  logic raw_pg = 1'b0;
  logic raw_ch = 1'b0;
  logic raw_ro = 1'b0;
  logic raw_eb = 1'b0;

  entradas_condicionador_if ctl();

  entradas_condicionador #(
    .DEB_CYCLES(DEB),
    .TIMER_CYCLES(TMR),
    .CHATTER_LIMIT(CHAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .raw_start(raw_start),
    .raw_pg(raw_pg),
    .raw_ch(raw_ch),
    .raw_ro(raw_ro),
    .raw_eb(raw_eb),
    .ctl(ctl)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: a line's output flips once its last DEB synchronised samples all disagree with it;
  // CQ is simply "timer_run has been high for at least TMR consecutive edges".
  logic [4:0] seen1 = '0;
  logic [4:0] seen2 = '0;
  logic [4:0] exp_out = '0;
  bit         win [5][$];
  int         run_edges = 0;

  function automatic logic [4:0] raw_vec();
    return {raw_eb, raw_ro, raw_ch, raw_pg, raw_start};
  endfunction

  function automatic logic [4:0] deb_vec();
    return {ctl.EB, ctl.RO, ctl.CH, ctl.PG, ctl.start};
  endfunction

  task automatic model_edge();
    logic [4:0] s;
    bit all_diff;
    if (reset) begin
      seen1 = '0;
      seen2 = '0;
      exp_out = '0;
      for (int i = 0; i < 5; i++) win[i].delete();
      run_edges = 0;
    end else begin
      s = seen2;
      seen2 = seen1;
      seen1 = raw_vec();
      for (int i = 0; i < 5; i++) begin
        win[i].push_back(s[i]);
        if (win[i].size() > DEB) void'(win[i].pop_front());
        all_diff = (win[i].size() == DEB);
        foreach (win[i][k]) if (win[i][k] == exp_out[i]) all_diff = 0;
        if (all_diff) exp_out[i] = ~exp_out[i];
      end
      if (ctl.timer_run) run_edges = (run_edges < TMR) ? run_edges + 1 : run_edges;
      else run_edges = 0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] raw, input logic run);
    {raw_eb, raw_ro, raw_ch, raw_pg, raw_start} = raw;
    ctl.timer_run = run;
  endtask

  task automatic tick(input int n);
    for (int c = 0; c < n; c++) begin
      model_edge();
      @(posedge clock);
      #1;
      checkOutput("deb", 8'(deb_vec()), 8'(exp_out));
      checkOutput("cq", 8'(ctl.CQ), 8'(run_edges >= TMR));
`ifndef ENTRADAS_CHATTER_EN
      checkOutput("fault_off", 8'(ctl.sensor_fault), 8'h00);
`endif
    end
  endtask

  initial begin
    logic [4:0] r;
    logic run;
    ctl.timer_run = 1'b0;

    // Reset dominance, then 18-cycle latency from release
    reset = 1'b1;
    applyStimulus(5'b11111, 1'b0);
    tick(3);
    checkOutput("reset_all_zero", {deb_vec(), ctl.CQ, ctl.sensor_fault, 1'b0}, 8'h00);
    reset = 1'b0;
    tick(17);
    checkOutput("lat17_still_low", 8'(deb_vec()), 8'h00);
    tick(1);
    checkOutput("lat18_all_high", 8'(deb_vec()), 8'h1F);

    applyStimulus(5'b00000, 1'b0);
    tick(20);
    checkOutput("all_fall", 8'(deb_vec()), 8'h00);

    // Glitch rejection on RO, then a real edge
    applyStimulus(5'b01000, 1'b0);
    tick(10);
    applyStimulus(5'b00000, 1'b0);
    tick(20);
    checkOutput("ro_glitch_rejected", 8'(ctl.RO), 8'h00);
    applyStimulus(5'b01000, 1'b0);
    tick(17);
    checkOutput("ro_lat17", 8'(ctl.RO), 8'h00);
    tick(1);
    checkOutput("ro_lat18", 8'(ctl.RO), 8'h01);
    tick(2);
    checkOutput("ro_holds", 8'(ctl.RO), 8'h01);

    // Parallel channels: PG+EB rise together, CH falls 5 cycles later
    applyStimulus(5'b01100, 1'b0);
    tick(20);
    applyStimulus(5'b11110, 1'b0);
    tick(5);
    applyStimulus(5'b11010, 1'b0);
    tick(12);
    checkOutput("pg_eb_lat17", 8'({ctl.PG, ctl.EB}), 8'h00);
    tick(1);
    checkOutput("pg_eb_same_edge", 8'({ctl.PG, ctl.EB}), 8'h03);
    tick(4);
    checkOutput("ch_before_fall", 8'(ctl.CH), 8'h01);
    tick(1);
    checkOutput("ch_fall_plus5", 8'(ctl.CH), 8'h00);

    // Timer expiry and drop
    applyStimulus(5'b00000, 1'b1);
    tick(9);
    checkOutput("cq_edge9", 8'(ctl.CQ), 8'h00);
    tick(1);
    checkOutput("cq_edge10", 8'(ctl.CQ), 8'h01);
    tick(3);
    checkOutput("cq_holds", 8'(ctl.CQ), 8'h01);
    ctl.timer_run = 1'b0;
    tick(1);
    checkOutput("cq_drop", 8'(ctl.CQ), 8'h00);

    // Abort/restart: no accumulation across a one-cycle drop
    ctl.timer_run = 1'b1;
    tick(7);
    ctl.timer_run = 1'b0;
    tick(1);
    ctl.timer_run = 1'b1;
    tick(9);
    checkOutput("cq_restart9", 8'(ctl.CQ), 8'h00);
    tick(1);
    checkOutput("cq_restart10", 8'(ctl.CQ), 8'h01);
    ctl.timer_run = 1'b0;
    tick(20);

    // Chatter on CH: toggle every 6 cycles for 60 cycles
    for (int k = 0; k < 10; k++) begin
      raw_ch = (k % 2 == 0);
      tick(6);
    end
    raw_ch = 1'b0;
    tick(10);
    checkOutput("ch_never_changed", 8'(ctl.CH), 8'h00);
`ifdef ENTRADAS_CHATTER_EN
    checkOutput("fault_set", 8'(ctl.sensor_fault), 8'h01);
    tick(30);
    checkOutput("fault_sticky", 8'(ctl.sensor_fault), 8'h01);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checkOutput("fault_cleared", 8'(ctl.sensor_fault), 8'h00);
`endif

    // Random traffic with occasional resets
    r = '0;
    run = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(0, 39) == 0) r[i] = ~r[i];
      end
      if ($urandom_range(0, 14) == 0) run = ~run;
      reset = ($urandom_range(0, 299) == 0);
      applyStimulus(r, run);
      tick(1);
    end

    reset = 1'b1;
    tick(1);
    checkOutput("final_reset", {deb_vec(), ctl.CQ, ctl.sensor_fault, 1'b0}, 8'h00);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
